i2s_mic_sequencer: RTL and testbench
====================================

# i2s_mic_sequencer

Timing and control sequencer for the I2S microphone front end. It generates the mic bit clock and word select from the system clock, and runs a mic start-up warm-up period. It issues per-bit strobes that drive the capture shift register, CIC integrator and comb stages, and it produces the decimated-sample valid pulse. Divider and decimation ratio are runtime-configurable, and a clean start/stop handshake lets the spectrogram top park the microphone between captures.

## Interface
- WARMUP_FRAMES, 1024: number of 64-bit I2S frames discarded after start (mic settling, about 22 ms at 3 MHz).
- CHAN, 0: word-select level whose slot is captured (0 = left).
- CLK  in  1  system clock (120 MHz nominal).
- RST  in  1  asynchronous, active-low reset.
- i_en  in  1  level; 1 = run, 0 = request stop.
- i_half_div  in  8  CLK cycles per mic_clk half period, minus 1; values below 2 are clamped to 2.
- i_dec_log2  in  2  decimation R = 2^i_dec_log2; 0 is treated as 1 (R ∈ {2,4,8}).
- o_mic_clk  out  1  I2S bit clock to the mic.
- o_mic_ws  out  1  I2S word select.
- o_bit_stb  out  1  one-CLK pulse at each mic_clk 1→0 transition (data sample point).
- o_bit_idx  out  6  bit index within the current half frame (0..31), valid with o_bit_stb.
- o_shift_clr  out  1  capture-slot strobe at bit 1.
- o_shift_en  out  1  capture-slot strobe at bits 2..25.
- o_integ_stb  out  1  capture-slot strobe at bit 26.
- o_comb_stb  out  1  capture-slot strobe at bit 27 when dec_cnt = R-1.
- o_vld  out  1  one-CLK decimated-sample valid.
- o_busy  out  1  state ≠ IDLE.
- o_ready  out  1  state ∈ {RUN, DRAIN}.

## Operation
- States: IDLE, WARMUP, RUN, DRAIN.
- IDLE
  - Counters are zero; o_mic_clk = 0; o_mic_ws = 0.
  - On i_en = 1: latch the clamped i_half_div and i_dec_log2, then go to WARMUP.
  - Config is sampled only at this transition; changes while busy are ignored.
- Divider
  - div_cnt counts 0..half_div.
  - At div_cnt = half_div: div_cnt ← 0 and mic_clk toggles.
  - If mic_clk was 1 at that moment, assert o_bit_stb, then advance bit_idx.
- Frame counting
  - bit_idx wraps 31→0; on wrap, ws toggles.
  - A frame is one ws=0 half plus one ws=1 half (64 bits).
  - dec_cnt (0..R-1) increments on each ws 1→0 wrap and wraps at R-1.
- Slot strobes
  - o_shift_clr / o_shift_en / o_integ_stb / o_comb_stb are o_bit_stb qualified by ws = CHAN plus the bit_idx/dec_cnt condition listed above.
  - They are suppressed in WARMUP.
- o_vld
  - Asserted on the ws 1→0 wrap where dec_cnt wraps R-1→0, in RUN or DRAIN only.
- WARMUP
  - frame_cnt counts ws 1→0 wraps.
  - At frame_cnt = WARMUP_FRAMES-1 on a wrap, go to RUN; dec_cnt = 0 at entry.
  - i_en = 0 in WARMUP: go to IDLE next cycle.
- RUN
  - i_en = 0: go to DRAIN.
- DRAIN
  - Clocks and strobes continue.
  - On the o_vld cycle, go to IDLE; that final o_vld is still issued.
  - i_en = 1 during DRAIN: return to RUN with no clock interruption.
- Entering IDLE clears div_cnt, bit_idx, dec_cnt, frame_cnt, mic_clk and ws in the same edge.

## Timing
- All outputs are registered; reset value of every output is 0.
- mic_clk period = 2·(half_div+1) CLK cycles. Example: half_div = 19 gives a 40-cycle period, 3 MHz at 120 MHz.
- ws half period = 32 mic_clk periods. Frame = 64·2·(half_div+1) CLK cycles; 2560 cycles at half_div = 19.
- o_vld period = R frames; 20480 CLK cycles at half_div = 19, R = 8.
- i_en to first mic_clk rise: IDLE→WARMUP takes 1 cycle, then a further half_div+1 cycles.
- Strobes coincide with the CLK edge on which mic_clk falls. They are all single-cycle and mutually exclusive, except that o_vld may coincide with o_bit_stb of bit 31.
- Asynchronous reset mid-operation: all state returns to IDLE immediately, outputs go to 0, no partial o_vld is emitted, and config is relatched on the next start.
- Widths:
  - div_cnt 8 bits
  - bit_idx 5 bits internal, zero-extended to 6 on the port
  - dec_cnt 3 bits
  - frame_cnt ceil(log2(WARMUP_FRAMES)) bits, minimum 1

## Test plan
- Reset:
  - Assert RST = 0 mid-RUN -> all outputs 0 within the same cycle (async).
  - Release with i_en = 0 -> outputs stay 0 and o_busy = 0.
- Clock generation:
  - half_div = 19, i_en = 1, WARMUP_FRAMES = 2 -> mic_clk period 40 cycles, ws toggles every 1280 cycles.
  - No slot strobes or o_vld during the first 5120 cycles; o_ready rises at the end of frame 2.
- Slot strobes:
  - In RUN with CHAN = 0 -> per ws = 0 half: 1 shift_clr, 24 shift_en, 1 integ_stb at bit 26; none in the ws = 1 half.
- Decimation:
  - i_dec_log2 = 3 -> o_comb_stb and o_vld once per 8 frames (20480 cycles at half_div = 19).
  - i_dec_log2 = 2 -> 10240 cycles; i_dec_log2 = 0 behaves as R = 2.
- Stop handshake:
  - Drop i_en in frame 3 of an 8-frame decimation -> exactly one more o_vld, then IDLE with mic_clk = 0.
  - Re-raise i_en in DRAIN -> RUN with continuous mic_clk.
- Clamp:
  - i_half_div = 0 -> mic_clk period 6 cycles.
  - Change i_half_div while busy -> period unchanged until the next IDLE→WARMUP.

Source files
------------

// File: rtl/i2s_mic_sequencer.sv
// i2s_mic_sequencer: I2S mic bit clock / word-select generator with start-up warm-up,
// per-bit capture/CIC strobes, decimated-sample valid and a start/stop handshake.
module i2s_mic_sequencer #(
    parameter int unsigned WARMUP_FRAMES = 1024,
    parameter bit          CHAN          = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_en,
    input  logic [7:0] i_half_div,
    input  logic [1:0] i_dec_log2,
    output logic       o_mic_clk,
    output logic       o_mic_ws,
    output logic       o_bit_stb,
    output logic [5:0] o_bit_idx,
    output logic       o_shift_clr,
    output logic       o_shift_en,
    output logic       o_integ_stb,
    output logic       o_comb_stb,
    output logic       o_vld,
    output logic       o_busy,
    output logic       o_ready
);

    localparam int unsigned   FW         = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(WARMUP_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, WARMUP, RUN, DRAIN} state_t;

    state_t        r_state;
    logic [7:0]    r_half_div;
    logic [2:0]    r_dec_max;
    logic [7:0]    r_div_cnt;
    logic [4:0]    r_bit_idx;
    logic [2:0]    r_dec_cnt;
    logic [FW-1:0] r_frame_cnt;
    logic          r_mic_clk;
    logic          r_ws;
    logic          r_bit_stb;
    logic [5:0]    r_bit_idx_o;
    logic          r_shift_clr;
    logic          r_shift_en;
    logic          r_integ_stb;
    logic          r_comb_stb;
    logic          r_vld;
    logic          r_busy;
    logic          r_ready;

    state_t        w_state_nxt;
    logic          w_tick;
    logic          w_fall;
    logic          w_wrap;
    logic          w_frame_end;
    logic          w_dec_wrap;
    logic          w_active;
    logic          w_slot;
    logic          w_vld;
    logic [7:0]    w_hd_clamp;
    logic [2:0]    w_dec_max;

    // Divider/frame events, config decode and next-state selection
    always_comb begin
        w_tick      = (r_state != IDLE) && (r_div_cnt == r_half_div);
        w_fall      = w_tick && r_mic_clk;
        w_wrap      = w_fall && (r_bit_idx == 5'd31);
        w_frame_end = w_wrap && r_ws;
        w_dec_wrap  = (r_dec_cnt == r_dec_max);
        w_active    = (r_state == RUN) || (r_state == DRAIN);
        w_slot      = w_fall && w_active && (r_ws == CHAN);
        w_vld       = w_frame_end && w_dec_wrap && w_active;
        w_hd_clamp  = (i_half_div < 8'd2) ? 8'd2 : i_half_div;
        case (i_dec_log2)
            2'd2:    w_dec_max = 3'd3;
            2'd3:    w_dec_max = 3'd7;
            default: w_dec_max = 3'd1;   // 0 behaves as 1 -> R = 2
        endcase

        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_en) w_state_nxt = WARMUP;
            WARMUP: begin
                if (!i_en) begin
                    w_state_nxt = IDLE;
                end else if (w_frame_end && (r_frame_cnt == FRAME_LAST)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN:     if (!i_en) w_state_nxt = DRAIN;
            DRAIN: begin
                // Re-enable wins over the final sample so the clock never stops
                if (i_en) begin
                    w_state_nxt = RUN;
                end else if (w_vld) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM, counters, config latch and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= IDLE;
            r_half_div  <= 8'd0;
            r_dec_max   <= 3'd0;
            r_div_cnt   <= 8'd0;
            r_bit_idx   <= 5'd0;
            r_dec_cnt   <= 3'd0;
            r_frame_cnt <= '0;
            r_mic_clk   <= 1'b0;
            r_ws        <= 1'b0;
            r_bit_stb   <= 1'b0;
            r_bit_idx_o <= 6'd0;
            r_shift_clr <= 1'b0;
            r_shift_en  <= 1'b0;
            r_integ_stb <= 1'b0;
            r_comb_stb  <= 1'b0;
            r_vld       <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_ready     <= (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
            r_bit_stb   <= w_fall;
            r_shift_clr <= w_slot && (r_bit_idx == 5'd1);
            r_shift_en  <= w_slot && (r_bit_idx >= 5'd2) && (r_bit_idx <= 5'd25);
            r_integ_stb <= w_slot && (r_bit_idx == 5'd26);
            r_comb_stb  <= w_slot && (r_bit_idx == 5'd27) && w_dec_wrap;
            r_vld       <= w_vld;
            if (w_fall) begin
                r_bit_idx_o <= {1'b0, r_bit_idx};
            end

            if ((r_state == IDLE) && i_en) begin
                r_half_div <= w_hd_clamp;
                r_dec_max  <= w_dec_max;
            end

            if (w_state_nxt == IDLE) begin
                r_div_cnt   <= 8'd0;
                r_bit_idx   <= 5'd0;
                r_dec_cnt   <= 3'd0;
                r_frame_cnt <= '0;
                r_mic_clk   <= 1'b0;
                r_ws        <= 1'b0;
            end else if (r_state != IDLE) begin
                if (w_tick) begin
                    r_div_cnt <= 8'd0;
                    r_mic_clk <= ~r_mic_clk;
                    if (w_fall) begin
                        r_bit_idx <= r_bit_idx + 5'd1;
                    end
                    if (w_wrap) begin
                        r_ws <= ~r_ws;
                    end
                    if (w_frame_end) begin
                        // dec_cnt stays 0 through warm-up so RUN starts a fresh decimation
                        if (r_state == WARMUP) begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end else begin
                            r_dec_cnt <= w_dec_wrap ? 3'd0 : r_dec_cnt + 3'd1;
                        end
                    end
                end else begin
                    r_div_cnt <= r_div_cnt + 8'd1;
                end
            end
        end
    end

    assign o_mic_clk   = r_mic_clk;
    assign o_mic_ws    = r_ws;
    assign o_bit_stb   = r_bit_stb;
    assign o_bit_idx   = r_bit_idx_o;
    assign o_shift_clr = r_shift_clr;
    assign o_shift_en  = r_shift_en;
    assign o_integ_stb = r_integ_stb;
    assign o_comb_stb  = r_comb_stb;
    assign o_vld       = r_vld;
    assign o_busy      = r_busy;
    assign o_ready     = r_ready;

endmodule

// File: tb/tb_i2s_mic_sequencer.sv
// tb_i2s_mic_sequencer: directed bench with an o_vld timing scoreboard and strobe counters.
module tb_i2s_mic_sequencer;

    logic       CLK;
    logic       RST;
    logic       i_en;
    logic [7:0] i_half_div;
    logic [1:0] i_dec_log2;
    logic       o_mic_clk;
    logic       o_mic_ws;
    logic       o_bit_stb;
    logic [5:0] o_bit_idx;
    logic       o_shift_clr;
    logic       o_shift_en;
    logic       o_integ_stb;
    logic       o_comb_stb;
    logic       o_vld;
    logic       o_busy;
    logic       o_ready;

    i2s_mic_sequencer #(
        .WARMUP_FRAMES(2),
        .CHAN         (1'b0)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .i_en       (i_en),
        .i_half_div (i_half_div),
        .i_dec_log2 (i_dec_log2),
        .o_mic_clk  (o_mic_clk),
        .o_mic_ws   (o_mic_ws),
        .o_bit_stb  (o_bit_stb),
        .o_bit_idx  (o_bit_idx),
        .o_shift_clr(o_shift_clr),
        .o_shift_en (o_shift_en),
        .o_integ_stb(o_integ_stb),
        .o_comb_stb (o_comb_stb),
        .o_vld      (o_vld),
        .o_busy     (o_busy),
        .o_ready    (o_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int exp_vld[$];     // scoreboard: expected cycle numbers of each o_vld

    // Monitor state, written only by the monitor process
    int   cyc = 0;
    int   last_rise = 0, clk_per = 0, n_rise = 0;
    int   last_ws = 0, ws_per = 0;
    int   ready_rise = -1;
    int   cnt_clr = 0, cnt_en = 0, cnt_integ = 0, cnt_comb = 0, cnt_vld = 0;
    int   n_ws1 = 0, n_overlap = 0, integ_idx = -1;
    logic prev_clk = 1'b0, prev_ws = 1'b0, prev_ready = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] all_out();
        return {o_mic_clk, o_mic_ws, o_bit_stb, o_bit_idx, o_shift_clr, o_shift_en,
                o_integ_stb, o_comb_stb, o_vld, o_busy, o_ready};
    endfunction

    // Sample 1 time unit after each active edge; cyc numbers the edges
    always @(posedge CLK) begin
        #1;
        cyc = cyc + 1;
        if (o_mic_clk && !prev_clk) begin
            clk_per   = cyc - last_rise;
            last_rise = cyc;
            n_rise    = n_rise + 1;
        end
        if (o_mic_ws != prev_ws) begin
            ws_per  = cyc - last_ws;
            last_ws = cyc;
        end
        if (o_ready && !prev_ready) ready_rise = cyc;
        prev_clk   = o_mic_clk;
        prev_ws    = o_mic_ws;
        prev_ready = o_ready;
        cnt_clr   += int'(o_shift_clr);
        cnt_en    += int'(o_shift_en);
        cnt_integ += int'(o_integ_stb);
        cnt_comb  += int'(o_comb_stb);
        if ((o_shift_clr | o_shift_en | o_integ_stb | o_comb_stb) && o_mic_ws) n_ws1++;
        if ($countones({o_shift_clr, o_shift_en, o_integ_stb, o_comb_stb, o_vld}) > 1 ||
            ((o_shift_clr | o_shift_en | o_integ_stb | o_comb_stb) && !o_bit_stb))
            n_overlap++;
        if (o_integ_stb) integ_idx = int'(o_bit_idx);
        if (o_vld) begin
            cnt_vld++;
            if (exp_vld.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL vld_unexpected: o_vld at cycle %0d, none expected", cyc);
            end else begin
                check("vld_time", cyc, exp_vld.pop_front());
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge CLK);
    endtask

    // Drive a start request; e0 is the edge on which IDLE->WARMUP happens
    task automatic start_run(input logic [7:0] h, input logic [1:0] d, output int e0);
        @(negedge CLK);
        i_half_div = h;
        i_dec_log2 = d;
        i_en       = 1'b1;
        e0         = cyc + 1;
        @(negedge CLK);
    endtask

    initial begin
        int e0, f, v1, v2, r1, s_comb, s_vld;
        RST        = 1'b0;
        i_en       = 1'b0;
        i_half_div = 8'd19;
        i_dec_log2 = 2'd3;
        repeat (3) @(negedge CLK);
        check("reset_outputs", int'(all_out()), 0);
        RST = 1'b1;
        repeat (5) @(negedge CLK);
        check("idle_busy", int'(o_busy), 0);
        check("idle_outputs", int'(all_out()), 0);

        // Phase A: half_div 19, R = 8, 2 warm-up frames
        f = 128 * 20;
        start_run(8'd19, 2'd3, e0);
        exp_vld.push_back(e0 + 10 * f);
        check("busy_after_start", int'(o_busy), 1);
        repeat (19) @(negedge CLK);
        check("mclk_low_before_rise", int'(o_mic_clk), 0);
        @(negedge CLK);
        check("mclk_first_rise", int'(o_mic_clk), 1);
        wait_until(e0 + 2 * f + 2);
        check("ready_rise_A", ready_rise, e0 + 2 * f);
        check("mclk_period_40", clk_per, 40);
        check("ws_half_period", ws_per, 1280);
        check("warmup_no_strobes", cnt_clr + cnt_en + cnt_integ + cnt_comb + cnt_vld, 0);
        wait_until(e0 + 3 * f + 2);
        check("frame_shift_clr", cnt_clr, 1);
        check("frame_shift_en", cnt_en, 24);
        check("frame_integ", cnt_integ, 1);
        check("frame_comb_none", cnt_comb, 0);
        check("integ_bit_idx", integ_idx, 26);
        i_half_div = 8'd0;   // must not take effect while busy
        wait_until(e0 + 10 * f + 2);
        check("comb_per_8_frames", cnt_comb, 1);
        check("vld_per_8_frames", cnt_vld, 1);
        check("period_held_A", clk_per, 40);
        repeat (100) @(negedge CLK);
        #2 RST = 1'b0;
        #1 check("async_reset_outputs", int'(all_out()), 0);
        @(negedge CLK);
        i_en = 1'b0;
        RST  = 1'b1;
        repeat (5) @(negedge CLK);
        check("release_idle", int'(all_out()), 0);

        // Phase B: half_div 0 clamps to 2 (period 6), stop in frame 3 of 8
        f = 128 * 3;
        start_run(8'd0, 2'd3, e0);
        s_vld = cnt_vld;
        v1 = e0 + 10 * f;
        exp_vld.push_back(v1);
        wait_until(e0 + 2 * f + 2);
        check("ready_rise_B", ready_rise, e0 + 2 * f);
        check("clamp_period_6", clk_per, 6);
        i_half_div = 8'd50;
        wait_until(v1 + 2 * f + 50);
        check("period_held_B", clk_per, 6);
        i_en = 1'b0;
        exp_vld.push_back(v1 + 8 * f);
        wait_until(v1 + 8 * f);
        check("drain_to_idle", int'({o_busy, o_ready, o_mic_clk, o_mic_ws}), 0);
        wait_until(v1 + 10 * f);
        check("drain_one_more_vld", cnt_vld - s_vld, 2);
        check("stays_idle", int'(o_busy), 0);

        // Phase C: dec_log2 0 behaves as R = 2; re-enable during DRAIN
        f = 128 * 4;
        start_run(8'd3, 2'd0, e0);
        v1 = e0 + 4 * f;
        v2 = e0 + 6 * f;
        exp_vld.push_back(v1);
        exp_vld.push_back(v2);
        wait_until(v1);
        r1 = n_rise;
        wait_until(v1 + 100);
        i_en = 1'b0;
        wait_until(v1 + 300);
        i_en = 1'b1;
        wait_until(v2);
        check("drain_resume_clock", n_rise - r1, 128);
        wait_until(v2 + 5);
        check("resume_running", int'({o_busy, o_ready}), 3);
        i_en = 1'b0;
        exp_vld.push_back(e0 + 8 * f);
        wait_until(e0 + 8 * f + 2);
        check("idle_after_C", int'(o_busy), 0);

        // Phase D: R = 4, stop right after warm-up
        start_run(8'd3, 2'd2, e0);
        s_comb = cnt_comb;
        exp_vld.push_back(e0 + 6 * f);
        wait_until(e0 + 2 * f + 10);
        i_en = 1'b0;
        wait_until(e0 + 6 * f + 2);
        check("idle_after_D", int'(o_busy), 0);
        check("comb_R4", cnt_comb - s_comb, 1);
        repeat (2 * f) @(negedge CLK);

        check("vld_all_seen", exp_vld.size(), 0);
        check("strobe_exclusive", n_overlap, 0);
        check("no_ws1_strobes", n_ws1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
